// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared control encodings for mc_ctrl_fsm (ctrl_encode_def): opcodes, funct codes,
// ALU operation codes, state encodings and the packed control-strobe bundle.
package mc_ctrl_fsm_pkg;

   localparam int unsigned StateW = 4;

   typedef enum logic [StateW-1:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StExecR  = 4'd6,
      StExecI  = 4'd7,
      StAluWb  = 4'd8,
      StBranch = 4'd9,
      StJump   = 4'd10,
      StHalt   = 4'd11
   } state_e;

   typedef enum logic [4:0] {
      AluAdd  = 5'd0,
      AluAddu = 5'd1,
      AluSub  = 5'd2,
      AluSubu = 5'd3,
      AluAnd  = 5'd4,
      AluOr   = 5'd5,
      AluNor  = 5'd6,
      AluSlt  = 5'd7,
      AluSll  = 5'd8,
      AluSrl  = 5'd9,
      AluBne  = 5'd10
   } alu_op_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpJ     = 6'b000010;

   localparam logic [5:0] FnAdd  = 6'b100000;
   localparam logic [5:0] FnAddu = 6'b100001;
   localparam logic [5:0] FnSub  = 6'b100010;
   localparam logic [5:0] FnSubu = 6'b100011;
   localparam logic [5:0] FnAnd  = 6'b100100;
   localparam logic [5:0] FnOr   = 6'b100101;
   localparam logic [5:0] FnNor  = 6'b100111;
   localparam logic [5:0] FnSlt  = 6'b101010;
   localparam logic [5:0] FnSll  = 6'b000000;
   localparam logic [5:0] FnSrl  = 6'b000010;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      alu_op_e    alu_ctrl;
   } ctrl_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller/datapath bundle: instruction fields and memory handshake toward the FSM,
// strobes, selects, state and error back toward the datapath.
interface mc_ctrl_fsm_if
   import mc_ctrl_fsm_pkg::*;
();
   logic [5:0]        op;
   logic [5:0]        funct;
   logic              zero;
   logic              mem_ready;
   logic              pc_write;
   logic              pc_write_cond;
   logic              i_or_d;
   logic              mem_read;
   logic              mem_write;
   logic              ir_write;
   logic              mem_to_reg;
   logic              reg_write;
   logic              reg_dst;
   logic              alu_src_a;
   logic [1:0]        alu_src_b;
   logic [1:0]        pc_source;
   logic [4:0]        alu_ctrl;
   logic [StateW-1:0] state_o;
   logic              err;

   modport master (
      input  op, funct, zero, mem_ready,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
             reg_write, reg_dst, alu_src_a, alu_src_b, pc_source, alu_ctrl, state_o, err
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
             reg_write, reg_dst, alu_src_a, alu_src_b, pc_source, alu_ctrl, state_o, err
   );
endinterface

// File: rtl/mc_ctrl_fsm_alu_ctrl_dec.sv
// R-type funct to ALU operation decoder; valid is low for any unlisted funct.
module alu_ctrl_dec
   import mc_ctrl_fsm_pkg::*;
(
   input  logic [5:0] funct,
   output alu_op_e    alu_ctrl,
   output logic       valid
);
   always_comb begin
      alu_ctrl = AluAdd;
      valid    = 1'b1;
      case (funct)
         FnAdd:   alu_ctrl = AluAdd;
         FnAddu:  alu_ctrl = AluAddu;
         FnSub:   alu_ctrl = AluSub;
         FnSubu:  alu_ctrl = AluSubu;
         FnAnd:   alu_ctrl = AluAnd;
         FnOr:    alu_ctrl = AluOr;
         FnNor:   alu_ctrl = AluNor;
         FnSlt:   alu_ctrl = AluSlt;
         FnSll:   alu_ctrl = AluSll;
         FnSrl:   alu_ctrl = AluSrl;
         default: valid    = 1'b0;
      endcase
   end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-style control FSM with memory-wait timeout.
// Define MC_ILLEGAL_TRAP_EN to halt with err on illegal op/funct instead of a NOP.
module mc_ctrl_fsm
   import mc_ctrl_fsm_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input logic           clk,
   input logic           rst_n,
   mc_ctrl_fsm_if.master bus
);
   localparam int unsigned    CntW    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] wait_q, wait_d;
   logic            err_q, err_d;
   logic            mem_wait, illegal;
   ctrl_t           ctrl, ctrl_out;
   alu_op_e         funct_alu;
   logic            funct_ok;
   logic            unused_zero;

   alu_ctrl_dec u_alu_ctrl_dec (
      .funct    (bus.funct),
      .alu_ctrl (funct_alu),
      .valid    (funct_ok)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wait_d   = '0;
      err_d    = err_q;
      mem_wait = 1'b0;
      illegal  = 1'b0;
      ctrl     = '0;
      unique case (state_q)
         StFetch: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = 2'b01;
            ctrl.alu_ctrl  = AluAddu;
            if (bus.mem_ready) begin
               ctrl.ir_write = 1'b1;
               ctrl.pc_write = 1'b1;
               state_d       = StDecode;
            end else begin
               mem_wait = 1'b1;
            end
         end
         StDecode: begin
            ctrl.alu_src_b = 2'b11;
            ctrl.alu_ctrl  = AluAddu;
            case (bus.op)
               OpLw, OpSw:     state_d = StMemAdr;
               OpAddi, OpOri:  state_d = StExecI;
               OpBeq, OpBne:   state_d = StBranch;
               OpJ:            state_d = StJump;
               OpRtype: begin
                  if (funct_ok) state_d = StExecR;
                  else          illegal = 1'b1;
               end
               default:        illegal = 1'b1;
            endcase
         end
         StMemAdr: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            ctrl.alu_ctrl  = AluAdd;
            state_d        = (bus.op == OpLw) ? StMemRd : StMemWr;
         end
         StMemRd: begin
            ctrl.i_or_d   = 1'b1;
            ctrl.mem_read = 1'b1;
            if (bus.mem_ready) state_d  = StMemWb;
            else               mem_wait = 1'b1;
         end
         StMemWr: begin
            ctrl.i_or_d    = 1'b1;
            ctrl.mem_write = 1'b1;
            if (bus.mem_ready) state_d  = StFetch;
            else               mem_wait = 1'b1;
         end
         StMemWb: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            state_d         = StFetch;
         end
         StExecR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_ctrl  = funct_alu;
            state_d        = StAluWb;
         end
         StExecI: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            ctrl.alu_ctrl  = (bus.op == OpAddi) ? AluAdd : AluOr;
            state_d        = StAluWb;
         end
         StAluWb: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = (bus.op == OpRtype);
            state_d        = StFetch;
         end
         StBranch: begin
            // The datapath gates pc_write_cond with zero for both beq and bne.
            ctrl.alu_src_a     = 1'b1;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = 2'b01;
            ctrl.alu_ctrl      = (bus.op == OpBeq) ? AluSubu : AluBne;
            state_d            = StFetch;
         end
         StJump: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = 2'b10;
            state_d        = StFetch;
         end
         StHalt:  state_d = StHalt;
         default: state_d = StFetch;
      endcase

      if (mem_wait) begin
         if (wait_q == CntLast) begin
            state_d = StHalt;
            err_d   = 1'b1;
         end else begin
            wait_d = wait_q + CntW'(1);
         end
      end

`ifdef MC_ILLEGAL_TRAP_EN
      if (illegal) begin
         state_d = StHalt;
         err_d   = 1'b1;
      end
`else
      if (illegal) state_d = StFetch;
`endif
   end

   // Strobes are held off for the whole reset pulse so an aborted access emits nothing.
   assign ctrl_out = rst_n ? ctrl : '0;

   assign bus.pc_write      = ctrl_out.pc_write;
   assign bus.pc_write_cond = ctrl_out.pc_write_cond;
   assign bus.i_or_d        = ctrl_out.i_or_d;
   assign bus.mem_read      = ctrl_out.mem_read;
   assign bus.mem_write     = ctrl_out.mem_write;
   assign bus.ir_write      = ctrl_out.ir_write;
   assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
   assign bus.reg_write     = ctrl_out.reg_write;
   assign bus.reg_dst       = ctrl_out.reg_dst;
   assign bus.alu_src_a     = ctrl_out.alu_src_a;
   assign bus.alu_src_b     = ctrl_out.alu_src_b;
   assign bus.pc_source     = ctrl_out.pc_source;
   assign bus.alu_ctrl      = ctrl_out.alu_ctrl;
   assign bus.state_o       = state_q;
   assign bus.err           = err_q;
   assign unused_zero       = bus.zero;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized self-checking bench for mc_ctrl_fsm against an instruction-path reference model.
// Honors MC_ILLEGAL_TRAP_EN the same way the design does.
module tb_mc_ctrl_fsm;
   localparam int unsigned TO = 8;

   localparam int SFetch = 0, SDecode = 1, SMemAdr = 2, SMemRd = 3, SMemWb = 4, SMemWr = 5;
   localparam int SExecR = 6, SExecI = 7, SAluWb = 8, SBranch = 9, SJump = 10, SHalt = 11;

   localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
   localparam logic [5:0] OpBeq = 6'b000100, OpBne = 6'b000101, OpAddi = 6'b001000;
   localparam logic [5:0] OpOri = 6'b001101, OpJ = 6'b000010;

   localparam logic [4:0] AluAdd = 5'd0, AluAddu = 5'd1, AluSub = 5'd2, AluSubu = 5'd3;
   localparam logic [4:0] AluAnd = 5'd4, AluOr = 5'd5, AluNor = 5'd6, AluSlt = 5'd7;
   localparam logic [4:0] AluSll = 5'd8, AluSrl = 5'd9, AluBne = 5'd10;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic err_exp = 1'b0;
   int   path_q[$];
   bit   path_illegal;

   logic [5:0] fn_tab [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2a,
                              6'h00, 6'h02};
   logic [4:0] fn_alu [10] = '{AluAdd, AluAddu, AluSub, AluSubu, AluAnd, AluOr, AluNor, AluSlt,
                              AluSll, AluSrl};

   mc_ctrl_fsm_if bus_if ();

   mc_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   logic [19:0] obs;
   assign obs = {bus_if.pc_write, bus_if.pc_write_cond, bus_if.i_or_d, bus_if.mem_read,
                 bus_if.mem_write, bus_if.ir_write, bus_if.mem_to_reg, bus_if.reg_write,
                 bus_if.reg_dst, bus_if.alu_src_a, bus_if.alu_src_b, bus_if.pc_source,
                 bus_if.alu_ctrl, bus_if.err};

   task automatic check_eq(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
      n_tests++;
      if (obs_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs_v, exp_v);
      end
   endtask

   function automatic int fn_index(logic [5:0] f);
      for (int i = 0; i < 10; i++) if (fn_tab[i] == f) return i;
      return -1;
   endfunction

   function automatic bit legal_op(logic [5:0] o);
      return o inside {OpR, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpOri, OpJ};
   endfunction

   // Sequence of states an instruction visits, as the instruction-class table describes.
   function automatic void build_path(logic [5:0] op, logic [5:0] fn);
      path_q.delete();
      path_q.push_back(SFetch);
      path_q.push_back(SDecode);
      path_illegal = 1'b0;
      case (op)
         OpLw:          begin path_q.push_back(SMemAdr); path_q.push_back(SMemRd);
                              path_q.push_back(SMemWb); end
         OpSw:          begin path_q.push_back(SMemAdr); path_q.push_back(SMemWr); end
         OpAddi, OpOri: begin path_q.push_back(SExecI); path_q.push_back(SAluWb); end
         OpBeq, OpBne:  path_q.push_back(SBranch);
         OpJ:           path_q.push_back(SJump);
         OpR: begin
            if (fn_index(fn) >= 0) begin
               path_q.push_back(SExecR);
               path_q.push_back(SAluWb);
            end else path_illegal = 1'b1;
         end
         default:       path_illegal = 1'b1;
      endcase
   endfunction

   function automatic logic [19:0] exp_vec(int st, logic [5:0] op, logic [5:0] fn, logic rdy,
                                           logic e);
      logic pw, pwc, iod, mrd, mwr, irw, m2r, rw, rd, asa;
      logic [1:0] asb, pcs;
      logic [4:0] alu;
      int idx;
      {pw, pwc, iod, mrd, mwr, irw, m2r, rw, rd, asa} = 10'b0;
      asb = 2'b00;
      pcs = 2'b00;
      alu = 5'd0;
      case (st)
         SFetch:  begin mrd = 1; asb = 2'b01; alu = AluAddu; irw = rdy; pw = rdy; end
         SDecode: begin asb = 2'b11; alu = AluAddu; end
         SMemAdr: begin asa = 1; asb = 2'b10; alu = AluAdd; end
         SMemRd:  begin iod = 1; mrd = 1; end
         SMemWr:  begin iod = 1; mwr = 1; end
         SMemWb:  begin rw = 1; m2r = 1; end
         SExecR:  begin
            asa = 1;
            idx = fn_index(fn);
            alu = (idx >= 0) ? fn_alu[idx] : AluAdd;
         end
         SExecI:  begin asa = 1; asb = 2'b10; alu = (op == OpAddi) ? AluAdd : AluOr; end
         SAluWb:  begin rw = 1; rd = (op == OpR); end
         SBranch: begin asa = 1; pwc = 1; pcs = 2'b01; alu = (op == OpBeq) ? AluSubu : AluBne; end
         SJump:   begin pw = 1; pcs = 2'b10; end
         default: ;
      endcase
      return {pw, pwc, iod, mrd, mwr, irw, m2r, rw, rd, asa, asb, pcs, alu, e};
   endfunction

   task automatic check_cycle(input string tag, input int st, input logic rdy);
      check_eq({tag, "_state"}, 32'(bus_if.state_o), 32'(st));
      check_eq({tag, "_outs"}, 32'(obs),
               32'(exp_vec(st, bus_if.op, bus_if.funct, rdy, err_exp)));
   endtask

   // Entered mid-cycle; leaves reset released at posedge+1 with no edge seen since release.
   task automatic do_reset();
      rst_n   = 1'b0;
      err_exp = 1'b0;
      #1;
      check_eq("rst_state", 32'(bus_if.state_o), 32'(SFetch));
      check_eq("rst_outs", 32'(obs), 32'(0));
      bus_if.mem_ready = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic walk(input logic [5:0] op, input logic [5:0] fn, input int max_stall,
                       input int stop_at, input int zero_val);
      string tag;
      bus_if.op    = op;
      bus_if.funct = fn;
      build_path(op, fn);
      for (int k = 0; k < path_q.size(); k++) begin
         int st   = path_q[k];
         bit is_m = (st == SFetch) || (st == SMemRd) || (st == SMemWr);
         int n    = is_m ? int'($urandom_range(max_stall, 0)) : 0;
         if (st == stop_at) return;
         tag = $sformatf("op%02h_st%0d", op, st);
         for (int i = 0; i < n; i++) begin
            bus_if.mem_ready = 1'b0;
            bus_if.zero      = 1'($urandom);
            #1 check_cycle({tag, "_wait"}, st, 1'b0);
            @(posedge clk);
            #1;
         end
         bus_if.mem_ready = is_m ? 1'b1 : 1'($urandom);
         bus_if.zero      = (zero_val < 0) ? 1'($urandom) : 1'(zero_val);
         #1 check_cycle(tag, st, bus_if.mem_ready);
         @(posedge clk);
         #1;
      end
      if (path_illegal) begin
`ifdef MC_ILLEGAL_TRAP_EN
         err_exp = 1'b1;
         #1 check_cycle("illegal_trap", SHalt, bus_if.mem_ready);
         do_reset();
`else
         #1;
         check_eq("illegal_nop_state", 32'(bus_if.state_o), 32'(SFetch));
         check_eq("illegal_nop_err", 32'(bus_if.err), 32'(err_exp));
`endif
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1);
   end

   initial begin
      logic [5:0] rop, rfn;
      bus_if.op        = 6'd0;
      bus_if.funct     = 6'd0;
      bus_if.zero      = 1'b0;
      bus_if.mem_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      walk(OpLw, 6'h00, 0, -1, -1);
      walk(OpBne, 6'h00, 0, -1, 1);
      walk(OpR, 6'h27, 0, -1, -1);
      walk(6'b111111, 6'h00, 0, -1, -1);

      // Memory write that never completes.
      walk(OpSw, 6'h00, 0, SMemWr, -1);
      for (int i = 0; i < int'(TO); i++) begin
         bus_if.mem_ready = 1'b0;
         #1 check_cycle("to_wait", SMemWr, 1'b0);
         @(posedge clk);
         #1;
      end
      err_exp = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus_if.mem_ready = 1'b1;
         #1 check_cycle("halt_hold", SHalt, 1'b1);
         @(posedge clk);
         #1;
      end
      do_reset();

      // Reset mid-read must also clear the partially filled wait counter.
      walk(OpLw, 6'h00, 0, SMemRd, -1);
      for (int i = 0; i < int'(TO) - 2; i++) begin
         bus_if.mem_ready = 1'b0;
         #1 check_cycle("rd_wait", SMemRd, 1'b0);
         @(posedge clk);
         #1;
      end
      do_reset();
      for (int i = 0; i < int'(TO) - 1; i++) begin
         bus_if.mem_ready = 1'b0;
         #1 check_cycle("post_rst_wait", SFetch, 1'b0);
         @(posedge clk);
         #1;
      end
      do_reset();

      repeat (300) begin
         case ($urandom_range(8, 0))
            0: rop = OpLw;
            1: rop = OpSw;
            2: rop = OpR;
            3: rop = OpAddi;
            4: rop = OpOri;
            5: rop = OpBeq;
            6: rop = OpBne;
            7: rop = OpJ;
            default: begin
               rop = 6'($urandom);
               while (legal_op(rop)) rop = 6'($urandom);
            end
         endcase
         rfn = ($urandom_range(3, 0) != 0) ? fn_tab[$urandom_range(9, 0)] : 6'($urandom);
         walk(rop, rfn, 3, -1, -1);
      end
      #1;
      check_eq("end_state", 32'(bus_if.state_o), 32'(SFetch));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, max cycles waiting on mem_ready before err.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports op  in  6 and funct  in  6  opcode/function fields of the latched instruction.
REQ-005 SHALL have port zero  in  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  in  1  memory access complete this cycle.
REQ-007 SHALL have 1-bit outputs pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst and alu_src_a, each a datapath strobe or select.
REQ-008 SHALL have outputs alu_src_b  out  2, pc_source  out  2, alu_ctrl  out  5 (ALU operation code), state_o  out  4 (current state) and err  out  1 (sticky fault).

Function
REQ-009 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP and HALT.
REQ-010 SHALL drive every output not named for a state to 0 in that state.
REQ-011 FETCH SHALL assert mem_read, alu_src_b=01 and alu_ctrl=ADDU; ir_write and pc_write SHALL assert only in the cycle mem_ready=1, and that cycle SHALL advance to DECODE.
REQ-012 DECODE SHALL set alu_src_b=11 and alu_ctrl=ADDU (branch target), then go to: lw/sw -> MEMADR; R-type -> EXEC_R; addi/ori -> EXEC_I; beq/bne -> BRANCH; j -> JUMP; any other op -> illegal handling (REQ-021).
REQ-013 Opcodes SHALL be R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, ori 001101, j 000010.
REQ-014 MEMADR SHALL set alu_src_a=1, alu_src_b=10 and alu_ctrl=ADD, then go to MEMRD for lw or MEMWR for sw.
REQ-015 MEMRD and MEMWR SHALL hold i_or_d=1 with mem_read or mem_write; they SHALL stay until mem_ready=1, then MEMRD goes to MEMWB and MEMWR goes to FETCH.
REQ-016 MEMWB SHALL assert reg_write and mem_to_reg, reg_dst=0, then go to FETCH.
REQ-017 EXEC_R SHALL map funct to alu_ctrl (100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 000000 SLL, 000010 SRL) and set alu_src_a=1; ALUWB SHALL set reg_dst=1 for R-type and 0 for I-type, assert reg_write, then go to FETCH.
REQ-018 EXEC_I SHALL set alu_src_a=1, alu_src_b=10, alu_ctrl=ADD for addi or OR for ori, then go to ALUWB.
REQ-019 BRANCH SHALL set alu_src_a=1, pc_write_cond=1 and pc_source=01, with alu_ctrl=SUBU for beq or BNE for bne; both take the branch on zero=1; then go to FETCH.
REQ-020 JUMP SHALL assert pc_write with pc_source=10, then go to FETCH.
REQ-021 Illegal handling SHALL follow REQ-026; an unlisted R-type funct SHALL be treated the same as an illegal op.
REQ-022 A wait counter SHALL count consecutive mem_ready=0 cycles in FETCH/MEMRD/MEMWR; on reaching MEM_TIMEOUT it SHALL set err and go to HALT.
REQ-023 Latency from FETCH entry with mem_ready=1 every cycle SHALL be: j/beq/bne 3, R/I-ALU/sw 4, lw 5 cycles.
REQ-024 HALT SHALL be left only by reset; state_o SHALL be FETCH=0 through HALT=11 in REQ-009 order.

Reset
REQ-025 rst_n=0 SHALL asynchronously force FETCH and clear err and the wait counter; assertion mid-instruction SHALL abort it with no further strobes.

Configuration
REQ-026 With MC_ILLEGAL_TRAP_EN defined, an illegal op/funct SHALL set err and enter HALT; without it, that instruction SHALL return to FETCH as a NOP and err SHALL be set only by timeout.

Structure
REQ-027 ALUOp_* codes, opcode/funct constants and state encodings SHALL live in the shared ctrl_encode_def header.
REQ-028 The funct-to-alu_ctrl map SHALL be a sub-module alu_ctrl_dec; the next-state and output logic SHALL remain in mc_ctrl_fsm.

Verification
REQ-029 The bench SHALL show that with mem_ready=1 and op=100011, the states run FETCH, DECODE, MEMADR, MEMRD, MEMWB and reg_write=1 with mem_to_reg=1 in cycle 5.
REQ-030 The bench SHALL show that with op=000101 and zero=1 in BRANCH, alu_ctrl=BNE, pc_write_cond=1 and pc_source=01.
REQ-031 The bench SHALL show that R-type funct=100111 gives alu_ctrl=NOR in EXEC_R, then reg_write=1 with reg_dst=1.
REQ-032 The bench SHALL show that with mem_ready held at 0 in MEMWR for MEM_TIMEOUT cycles, err=1 and state_o=11.
REQ-033 The bench SHALL show that op=111111 gives HALT with err=1 when MC_ILLEGAL_TRAP_EN is defined, and FETCH with err=0 when it is not.
REQ-034 The bench SHALL show that rst_n pulled low in MEMRD forces state_o=0 at once and all strobes to 0.
